// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_responder_if
// Desc    : Fetch read port bundle between the fetch unit and imem_responder.
// Rev     : 1.0
// ============================================================================
interface imem_responder_if;
  logic        mem_r_en;
  logic [15:0] mem_r_addr;
  logic [15:0] mem_r_data;
  logic        mem_r_valid;
  logic        stall;

  modport master (
    output mem_r_en,
    output mem_r_addr,
    input  mem_r_data,
    input  mem_r_valid,
    input  stall
  );

  modport slave (
    input  mem_r_en,
    input  mem_r_addr,
    output mem_r_data,
    output mem_r_valid,
    output stall
  );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : imem_responder
// Desc    : Instruction RAM answering fetch reads after WAIT_STATES wait states,
//           with a load port for program words. Define IMEM_HIT_BUF_EN to add a
//           one-word buffer that returns a repeated address in one cycle.
// Rev     : 1.0
// ============================================================================
module imem_responder #(
  parameter int DEPTH       = 256,
  parameter int IDX_W       = 8,
  parameter int WAIT_STATES = 2
) (
  input  wire             clk,
  input  wire             reset,
  imem_responder_if.slave bus,
  input  wire             ld_en,
  input  wire [15:0]      ld_addr,
  input  wire [15:0]      ld_data,
  output logic            addr_err,
  input  wire             err_clr
);

  localparam logic [16:0] c_DEPTH    = 17'(DEPTH);
  localparam logic [3:0]  c_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic        c_HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [15:0]      r_req_addr;
  logic [15:0]      r_data;
  logic             r_err;
  logic [15:0]      r_mem [DEPTH];

  logic             w_accept, w_hit, w_enter_resp, w_stall;
  logic             w_rd_oor, w_ld_oor, w_ld_ok;
  logic [15:0]      w_rd_addr, w_rd_word;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_accept  = bus.mem_r_en & ((r_state == ST_IDLE) | (r_state == ST_RESP));
  // On the accept cycle the address is still on the bus, not yet latched.
  assign w_rd_addr = w_accept ? bus.mem_r_addr : r_req_addr;
  assign w_rd_idx  = w_rd_addr[IDX_W-1:0];
  assign w_rd_oor  = ({1'b0, w_rd_addr} >= c_DEPTH);
  assign w_ld_oor  = ({1'b0, ld_addr} >= c_DEPTH);
  assign w_ld_ok   = ld_en & !w_ld_oor;

`ifdef IMEM_HIT_BUF_EN
  logic        r_hb_valid;
  logic [15:0] r_hb_addr, r_hb_data;

  // A load to the buffered address in the same cycle forces the slow path.
  assign w_hit = w_accept & r_hb_valid & (bus.mem_r_addr == r_hb_addr)
               & !(ld_en & (ld_addr == r_hb_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hb_valid <= 1'b0;
      r_hb_addr  <= 16'h0000;
      r_hb_data  <= 16'h0000;
    end else if (w_enter_resp & !w_rd_oor) begin
      r_hb_valid <= 1'b1;
      r_hb_addr  <= w_rd_addr;
      r_hb_data  <= w_rd_word;
    end else if (ld_en & (ld_addr == r_hb_addr)) begin
      r_hb_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_stall = (r_cnt != 4'd0);
        if (r_cnt == 4'd0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (w_accept) begin
          if (w_hit | !c_HAS_WAIT) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
            w_stall     = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Write-first: a load landing on the index being captured wins.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_rd_oor)
      w_rd_word = 16'h0000;
`ifdef IMEM_HIT_BUF_EN
    else if (w_hit)
      w_rd_word = r_hb_data;
`endif
    else if (w_ld_ok & (ld_addr == w_rd_addr))
      w_rd_word = ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_addr <= 16'h0000;
      r_data     <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      if (w_accept)
        r_req_addr <= bus.mem_r_addr;
      if (w_enter_resp)
        r_data <= w_rd_word;
      r_err <= (w_enter_resp & w_rd_oor) | (ld_en & w_ld_oor) | (r_err & !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_ok)
      r_mem[ld_addr[IDX_W-1:0]] <= ld_data;
  end

  assign bus.mem_r_data  = r_data;
  assign bus.mem_r_valid = (r_state == ST_RESP);
  assign bus.stall       = w_stall & reset;
  assign addr_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_responder
// Desc    : Self-checking bench: vector table, directed corner sequences and a
//           randomized run against a cycle-count reference model.
// Rev     : 1.0
// ============================================================================
module tb_imem_responder;

`ifdef IMEM_HIT_BUF_EN
  localparam bit c_HB = 1'b1;
`else
  localparam bit c_HB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_responder_if bus_a ();
  imem_responder_if bus_b ();

  logic        ld_en_a, ld_en_b, err_clr_a, err_clr_b, err_a, err_b;
  logic [15:0] ld_addr_a, ld_data_a, ld_addr_b, ld_data_b;

  imem_responder #(.DEPTH(256), .IDX_W(8), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a),
    .addr_err(err_a), .err_clr(err_clr_a)
  );

  imem_responder #(.DEPTH(256), .IDX_W(8), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b),
    .addr_err(err_b), .err_clr(err_clr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] a, input logic [15:0] d);
    tick();
    ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
    tick();
    ld_en_a = 1'b0;
  endtask

  // Single read on DUT A: measure accept->valid latency and stall cycles.
  task automatic read_a(input logic [15:0] a, input logic [15:0] exp_d,
                        input int exp_lat, input int exp_stalls, input string nm);
    int ns, seen;
    tick();
    bus_a.mem_r_en = 1'b1; bus_a.mem_r_addr = a;
    @(negedge clk);
    ns   = int'(bus_a.stall);
    seen = 0;
    tick();
    bus_a.mem_r_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus_a.mem_r_valid) begin
        seen = k;
        break;
      end
      ns += int'(bus_a.stall);
      tick();
    end
    chk({nm, "_latency"}, seen, exp_lat);
    chk({nm, "_data"}, bus_a.mem_r_data, exp_d);
    chk({nm, "_stalls"}, ns, exp_stalls);
  endtask

  typedef struct {
    logic [15:0] la;
    logic [15:0] ld;
    logic [15:0] ra;
    logic [15:0] exp_d;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  // Reference model state for the randomized run
  logic [15:0] mm [256];
  int          cyc, last_resp;
  logic [15:0] pend_a, e_data, hb_a, hb_d;
  bit          pend_hit, e_err, hb_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          en, le, ec, acc, hit, e_valid, e_stall, set_err;
    logic [15:0] ra, la, ld, d;
    int          r, nvalid;

    reset = 1'b0;
    bus_a.mem_r_en = 1'b1; bus_a.mem_r_addr = 16'h0000;
    bus_b.mem_r_en = 1'b0; bus_b.mem_r_addr = 16'h0000;
    ld_en_a = 0; ld_addr_a = 0; ld_data_a = 0; err_clr_a = 0;
    ld_en_b = 0; ld_addr_b = 0; ld_data_b = 0; err_clr_b = 0;

    // Reset state, with a request held high to show stall is forced low
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stall", bus_a.stall, 0);
    chk("rst_valid", bus_a.mem_r_valid, 0);
    chk("rst_data", bus_a.mem_r_data, 16'h0000);
    chk("rst_err", err_a, 0);
    tick();
    bus_a.mem_r_en = 1'b0;
    reset = 1'b1;

    tbl[0] = '{16'h0010, 16'hA5A5, 16'h0010, 16'hA5A5, 1'b0};
    tbl[1] = '{16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2] = '{16'h00FF, 16'hFFFF, 16'h00FF, 16'hFFFF, 1'b0};
    tbl[3] = '{16'h0100, 16'hDEAD, 16'h0000, 16'hBEEF, 1'b1};
    tbl[4] = '{16'h0011, 16'h0001, 16'h0011, 16'h0001, 1'b0};
    tbl[5] = '{16'h0030, 16'h1111, 16'h0100, 16'h0000, 1'b1};
    tbl[6] = '{16'h0012, 16'h3333, 16'h0112, 16'h0000, 1'b1};
    tbl[7] = '{16'h01FF, 16'h7777, 16'h00FF, 16'hFFFF, 1'b1};

    for (int i = 0; i < 8; i++) begin
      load_a(tbl[i].la, tbl[i].ld);
      read_a(tbl[i].ra, tbl[i].exp_d, 3, 2, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_err", i), err_a, tbl[i].exp_err);
      tick(); err_clr_a = 1'b1;
      tick(); err_clr_a = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_errclr", i), err_a, 0);
    end

    // Reset asserted while the read is waiting aborts it
    tick(); bus_a.mem_r_en = 1'b1; bus_a.mem_r_addr = 16'h0010;
    tick(); bus_a.mem_r_en = 1'b0;
    @(negedge clk);
    chk("midwait_stall_before", bus_a.stall, 1);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("midwait_stall", bus_a.stall, 0);
    chk("midwait_valid", bus_a.mem_r_valid, 0);
    chk("midwait_data", bus_a.mem_r_data, 16'h0000);
    tick(); reset = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvalid += int'(bus_a.mem_r_valid);
      tick();
    end
    chk("midwait_no_resp", nvalid, 0);
    read_a(16'h0010, 16'hA5A5, 3, 2, "post_reset");

    // Load landing on the same edge the response is captured
    load_a(16'h0020, 16'h0BAD);
    tick(); bus_a.mem_r_en = 1'b1; bus_a.mem_r_addr = 16'h0020;
    tick(); bus_a.mem_r_en = 1'b0;
    tick(); ld_en_a = 1'b1; ld_addr_a = 16'h0020; ld_data_a = 16'h1234;
    tick(); ld_en_a = 1'b0;
    @(negedge clk);
    chk("wrfirst_valid", bus_a.mem_r_valid, 1);
    chk("wrfirst_data", bus_a.mem_r_data, 16'h1234);

    // Clear and a new error in the same cycle: error stays set
    tick(); ld_en_a = 1'b1; ld_addr_a = 16'h8000; err_clr_a = 1'b1;
    tick(); ld_en_a = 1'b0; err_clr_a = 1'b0;
    @(negedge clk);
    chk("err_set_wins", err_a, 1);
    tick(); err_clr_a = 1'b1;
    tick(); err_clr_a = 1'b0;
    @(negedge clk);
    chk("err_cleared", err_a, 0);

    // Repeated address: buffered build answers in one cycle
    load_a(16'h0005, 16'h5555);
    read_a(16'h0005, 16'h5555, 3, 2, "hb_first");
    if (c_HB) read_a(16'h0005, 16'h5555, 1, 0, "hb_hit");
    else      read_a(16'h0005, 16'h5555, 3, 2, "hb_nobuf");
    load_a(16'h0005, 16'h6666);
    read_a(16'h0005, 16'h6666, 3, 2, "hb_after_load");

    // Zero wait states: one word per cycle, never a stall
    for (int i = 0; i < 3; i++) begin
      tick(); ld_en_b = 1'b1; ld_addr_b = 16'(i); ld_data_b = 16'hA000 + 16'(i);
    end
    tick(); ld_en_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_b.mem_r_en = (i < 3); bus_b.mem_r_addr = 16'(i);
      @(negedge clk);
      chk($sformatf("ws0_stall%0d", i), bus_b.stall, 0);
      if (i > 0) begin
        chk($sformatf("ws0_valid%0d", i), bus_b.mem_r_valid, 1);
        chk($sformatf("ws0_data%0d", i), bus_b.mem_r_data, 16'hA000 + 16'(i - 1));
      end
      tick();
    end
    bus_b.mem_r_en = 1'b0;

    // Randomized run on DUT A against the reference model
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      load_a(16'(i), d);
      mm[i] = d;
    end
    cyc = 0; last_resp = -10; e_data = 16'h0000; e_err = 1'b0;
    hb_v = 1'b0; hb_a = 16'h0000; hb_d = 16'h0000; pend_a = 16'h0000; pend_hit = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      en = ($urandom_range(0, 9) < 6);
      r  = $urandom_range(0, 19);
      ra = (r < 16) ? 16'(r) : ((r == 19) ? 16'hFFFF : 16'h00F0 + 16'(r) * 16'h0010);
      le = ($urandom_range(0, 9) < 3);
      r  = $urandom_range(0, 17);
      la = (r < 16) ? 16'(r) : 16'h0100 + 16'(r);
      ld = 16'($urandom);
      ec = ($urandom_range(0, 9) == 0);
      bus_a.mem_r_en = en; bus_a.mem_r_addr = ra;
      ld_en_a = le; ld_addr_a = la; ld_data_a = ld; err_clr_a = ec;

      acc     = en && (cyc >= last_resp);
      hit     = c_HB && acc && hb_v && (ra == hb_a) && !(le && la == hb_a);
      e_valid = (cyc == last_resp);
      e_stall = (acc && !hit) || (cyc < last_resp - 1);
      @(negedge clk);
      chk($sformatf("rnd_valid c%0d", cyc), bus_a.mem_r_valid, e_valid);
      chk($sformatf("rnd_data c%0d", cyc), bus_a.mem_r_data, e_data);
      chk($sformatf("rnd_stall c%0d", cyc), bus_a.stall, e_stall);
      chk($sformatf("rnd_err c%0d", cyc), err_a, e_err);

      if (acc) begin
        pend_a    = ra;
        pend_hit  = hit;
        last_resp = cyc + (hit ? 1 : 3);
      end
      set_err = le && (la >= 16'd256);
      if (last_resp == cyc + 1) begin
        if (pend_a >= 16'd256) begin
          d = 16'h0000;
          set_err = 1'b1;
        end else if (pend_hit) d = hb_d;
        else if (le && la == pend_a) d = ld;
        else d = mm[pend_a[7:0]];
        e_data = d;
        if (c_HB && pend_a < 16'd256) begin
          hb_v = 1'b1; hb_a = pend_a; hb_d = d;
        end
      end else if (hb_v && le && la == hb_a) begin
        hb_v = 1'b0;
      end
      e_err = set_err || (e_err && !ec);
      if (le && la < 16'd256) mm[la[7:0]] = ld;
      cyc++;
    end
    bus_a.mem_r_en = 1'b0; ld_en_a = 1'b0; err_clr_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
